sp_ram_clr: RTL and testbench
=============================

# sp_ram_clr

Parametrised single-port synchronous RAM with a valid/ready request port, a selectable read-during-write mode, an optional output register and a hardware clear engine. After reset, or on command, the clear engine writes `INIT_VAL` to every word. It is the general-purpose storage primitive for buffers and register files across the design, and it supersedes the fixed 4-bit single-port RAM.

## Interface
Parameters:
- `DATA_W`, 4: word width in bits.
- `ADDR_W`, 4: address width. Depth is `2**ADDR_W` words.
- `RDW_MODE`, 0: read-during-write behaviour. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- `OUT_REG`, 0: 1 adds an output pipeline register.
- `INIT_VAL`, 0: value written to every word by the clear engine.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `clear` in 1: single-cycle request to re-initialise the whole array.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when both `req_valid` and `req_ready` are high.
- `write_en` in 1: 1 = write request, 0 = read request.
- `address` in `ADDR_W`: word address.
- `write_data` in `DATA_W`: write payload.
- `read_data` out `DATA_W`: response data.
- `read_valid` out 1: `read_data` is valid this cycle (one pulse per response).
- `busy` out 1: clear engine is active.

## Operation
- FSM states: CLEAR and IDLE.
- `rst` forces CLEAR with the sweep counter at 0.
- In CLEAR, one word is written per cycle, address 0 up to `2**ADDR_W-1`, with `INIT_VAL`. When the last address is written, the FSM moves to IDLE.
- In IDLE, `clear`=1 moves the FSM to CLEAR with the counter reset to 0.
- `clear` is ignored while already in CLEAR; the sweep does not restart.
- `req_ready` = (state == IDLE) & ~`clear`. It is combinational, and `clear` has priority over a request in the same cycle.
- Accepted read: `read_data` = mem[`address`] and `read_valid`=1.
- Accepted write: mem[`address`] <= `write_data`. The response depends on `RDW_MODE`:
  - READ_FIRST: old word, `read_valid`=1.
  - WRITE_FIRST: `write_data`, `read_valid`=1.
  - NO_CHANGE: `read_data` holds, `read_valid`=0.
- No accepted request: `read_valid`=0 and `read_data` holds.
- Requests already accepted before a clear still produce their response. Responses are never dropped or reordered.
- Address decode is full (depth is a power of two), so there is no out-of-range case. The sweep counter is `ADDR_W` bits and its terminal value is all-ones.

## Timing
- Reset values: `read_data`=0, `read_valid`=0, `busy`=1, `req_ready`=0.
- The sweep takes exactly `2**ADDR_W` cycles, starting on the first clock edge after `rst` deasserts.
- `busy` falls and `req_ready` rises in the cycle after the last clear write.
- A clear command accepted at edge N sets `busy`=1 from N+1. The sweep writes address 0 at edge N+1.
- Response latency from the acceptance edge: 1 cycle when `OUT_REG`=0, 2 cycles when `OUT_REG`=1. Throughput is one request per cycle in IDLE.
- With `OUT_REG`=1, both `read_data` and `read_valid` pass through the extra stage. The stage's reset values are 0.
- `rst` asserted mid-sweep or mid-pipeline clears the FSM, the counter and all pipeline valids immediately. In-flight responses are lost and array contents are don't-care until the new sweep ends.
- Back-to-back write then read to the same address: the read returns the newly written data in every mode.

## Structure
- Shared package holds the `RDW_MODE` encodings (`RDW_READ_FIRST`, `RDW_WRITE_FIRST`, `RDW_NO_CHANGE`) and the FSM state encoding (`ST_CLEAR`, `ST_IDLE`).
- One sub-module, `sp_ram_core`: the bare array with one write port and one synchronous read port, so synthesis infers block RAM.
- The top level muxes the address and write data between the sweep counter and the request port, and contains the FSM and the optional output stage.

## Test plan
- Reset release with `ADDR_W`=4, `INIT_VAL`=4'hA -> `busy`=1 for exactly 16 cycles, then `req_ready`=1; reads of addresses 0..15 all return 4'hA.
- Write 4'h5 to address 3, then read address 3 the next cycle, with `OUT_REG`=0 and then 1 -> `read_data`=4'h5 with `read_valid` one cycle after acceptance (`OUT_REG`=0) and two cycles after (`OUT_REG`=1).
- Address 7 holds 4'h2; write 4'h9 to address 7 under each mode:
  - READ_FIRST -> response 4'h2, `read_valid`=1.
  - WRITE_FIRST -> response 4'h9, `read_valid`=1.
  - NO_CHANGE -> `read_valid`=0, `read_data` unchanged.
- Read address 2 and assert `clear` in the same IDLE cycle -> `req_ready`=0, no response for the read, sweep starts; a `clear` pulse 5 cycles into the sweep does not extend it beyond 16 cycles.
- Assert `rst` at sweep address 8 -> outputs return to reset values at once; the full 16-cycle sweep reruns after release.

Source files
------------

// File: rtl/sp_ram_clr_pkg.sv
// ---------------------------------------------------------------------------
// sp_ram_clr_pkg
// Shared definitions for the clearable single-port RAM:
//   - read-during-write mode encodings for the RDW_MODE parameter
//   - clear-engine FSM state encoding
// ---------------------------------------------------------------------------
package sp_ram_clr_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/sp_ram_core.sv
// ---------------------------------------------------------------------------
// sp_ram_core
// Bare single-port array: one write port and one registered read port, in
// the shape synthesis maps onto block RAM. The read is read-first: a read
// and a write to the same address on the same edge return the old word.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    async active-high reset of the read register only
//   i_we     write enable
//   i_re     read enable (read register holds when low)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data
// ---------------------------------------------------------------------------
module sp_ram_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Output-register reset is supported by block RAM primitives and gives
    // the top a defined zero on read_data after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sp_ram_clr.sv
// ---------------------------------------------------------------------------
// sp_ram_clr
// Single-port synchronous RAM with valid/ready request port, selectable
// read-during-write behaviour, optional output register and a clear engine
// that writes INIT_VAL to every word after reset or on a clear command.
// Ports:
//   clk         clock, rising edge
//   rst         async active-high reset
//   clear       single-cycle request to re-initialise the array (IDLE only)
//   req_valid   request present
//   req_ready   request accepted when req_valid & req_ready
//   write_en    1 = write, 0 = read
//   address     word address
//   write_data  write payload
//   read_data   response data (holds between responses)
//   read_valid  one-cycle pulse per response
//   busy        clear engine active
// ---------------------------------------------------------------------------
module sp_ram_clr
    import sp_ram_clr_pkg::*;
#(
    parameter int                DATA_W   = 4,
    parameter int                ADDR_W   = 4,
    parameter int                RDW_MODE = 0,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    logic              w_accept;
    logic              w_resp;
    logic              w_core_we;
    logic [ADDR_W-1:0] w_core_addr;
    logic [DATA_W-1:0] w_core_wdata;
    logic [DATA_W-1:0] w_core_q;

    logic              r_vld_p1;
    logic              r_wsel_p1;
    logic [DATA_W-1:0] r_wdata_p1;
    logic [DATA_W-1:0] w_rdata_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A clear seen while already sweeping is ignored so the sweep length is
    // always exactly one pass over the array.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy      = (r_state == ST_CLEAR);
    assign req_ready = (r_state == ST_IDLE) & ~clear;
    assign w_accept  = req_valid & req_ready;

    // Every read responds; a write responds unless the mode is NO_CHANGE.
    assign w_resp = w_accept & (~write_en | (RDW_MODE != RDW_NO_CHANGE));

    assign w_core_we    = busy | (w_accept & write_en);
    assign w_core_addr  = busy ? r_cnt : address;
    assign w_core_wdata = busy ? INIT_VAL : write_data;

    sp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_core_we),
        .i_re    (w_resp),
        .i_addr  (w_core_addr),
        .i_wdata (w_core_wdata),
        .o_rdata (w_core_q)
    );

    // ---- stage p1: response from the array, one edge after acceptance ----
    // WRITE_FIRST is built on the read-first core by steering the response to
    // the captured write payload. Select and payload only move on a response,
    // so the muxed value holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_wsel_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_resp;
            if (w_resp) begin
                r_wsel_p1 <= write_en & (RDW_MODE == RDW_WRITE_FIRST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_resp) begin
            r_wdata_p1 <= write_data;
        end
    end

    assign w_rdata_p1 = r_wsel_p1 ? r_wdata_p1 : w_core_q;

    // ---- stage p2: optional output register ----
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_rdata_p2;
            logic              r_vld_p2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdata_p2 <= '0;
                    r_vld_p2   <= 1'b0;
                end else begin
                    r_rdata_p2 <= w_rdata_p1;
                    r_vld_p2   <= r_vld_p1;
                end
            end

            assign read_data  = r_rdata_p2;
            assign read_valid = r_vld_p2;
        end else begin : g_no_out_reg
            assign read_data  = w_rdata_p1;
            assign read_valid = r_vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_clr.sv
module tb_sp_ram_clr;

    localparam int         DEPTH = 16;
    localparam logic [3:0] INIT  = 4'hA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       clear;
    logic       req_valid;
    logic       write_en;
    logic [3:0] address;
    logic [3:0] write_data;

    // Instances: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE (no output
    // register); 3 = READ_FIRST with output register.
    logic [3:0] rd  [4];
    logic       rv  [4];
    logic       bz  [4];
    logic       rdy [4];

    sp_ram_clr #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(INIT)) u_rf (
        .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(rdy[0]),
        .write_en(write_en), .address(address), .write_data(write_data),
        .read_data(rd[0]), .read_valid(rv[0]), .busy(bz[0]));
    sp_ram_clr #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(0), .INIT_VAL(INIT)) u_wf (
        .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(rdy[1]),
        .write_en(write_en), .address(address), .write_data(write_data),
        .read_data(rd[1]), .read_valid(rv[1]), .busy(bz[1]));
    sp_ram_clr #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(2), .OUT_REG(0), .INIT_VAL(INIT)) u_nc (
        .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(rdy[2]),
        .write_en(write_en), .address(address), .write_data(write_data),
        .read_data(rd[2]), .read_valid(rv[2]), .busy(bz[2]));
    sp_ram_clr #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(1), .INIT_VAL(INIT)) u_rf_oreg (
        .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(rdy[3]),
        .write_en(write_en), .address(address), .write_data(write_data),
        .read_data(rd[3]), .read_valid(rv[3]), .busy(bz[3]));

    // Reference model: memory contents, remaining sweep cycles, and the
    // visible response of each instance.
    logic [3:0] m_mem [DEPTH];
    int         sweep_left;
    logic [3:0] e_rd [4];
    logic       e_rv [4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        sweep_left = DEPTH;
        for (int i = 0; i < 4; i++) begin
            e_rd[i] = 4'h0;
            e_rv[i] = 1'b0;
        end
    endfunction

    // One rising edge of the specified behaviour.
    function automatic void model_edge();
        logic       acc;
        logic [3:0] old;
        logic [3:0] nd [3];
        logic       nv [3];
        // the registered-output instance shows what instance 0 showed a cycle ago
        e_rd[3] = e_rd[0];
        e_rv[3] = e_rv[0];
        acc = (sweep_left == 0) && !clear && req_valid;
        for (int m = 0; m < 3; m++) begin
            nd[m] = 4'h0;
            nv[m] = 1'b0;
        end
        if (acc) begin
            old = m_mem[address];
            if (!write_en) begin
                for (int m = 0; m < 3; m++) begin
                    nd[m] = old;
                    nv[m] = 1'b1;
                end
            end else begin
                nd[0] = old;        nv[0] = 1'b1;
                nd[1] = write_data; nv[1] = 1'b1;
                m_mem[address] = write_data;
            end
        end
        for (int m = 0; m < 3; m++) begin
            e_rv[m] = nv[m];
            if (nv[m]) e_rd[m] = nd[m];
        end
        if (sweep_left > 0) begin
            m_mem[DEPTH - sweep_left] = INIT;
            sweep_left--;
        end else if (clear) begin
            sweep_left = DEPTH;
        end
    endfunction

    // Check status at the falling edge, advance one rising edge, check data.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy[%0d]", i), bz[i], (sweep_left > 0) ? 1 : 0);
            chk($sformatf("req_ready[%0d]", i), rdy[i],
                (sweep_left == 0 && !clear && !rst) ? 1 : 0);
        end
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("read_data[%0d]", i), rd[i], e_rd[i]);
            chk($sformatf("read_valid[%0d]", i), rv[i], e_rv[i]);
        end
    endtask

    task automatic drive(input logic c, input logic v, input logic w,
                         input logic [3:0] a, input logic [3:0] d);
        clear      = c;
        req_valid  = v;
        write_en   = w;
        address    = a;
        write_data = d;
    endtask

    // Count edges until busy falls; optionally pulse clear at edge index clr_at.
    task automatic count_sweep(input string nm, input int clr_at);
        int n = 0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        while (bz[0] && n < 40) begin
            clear = (n == clr_at);
            step();
            n++;
        end
        clear = 1'b0;
        chk(nm, n, DEPTH);
    endtask

    typedef struct {
        logic       c;
        logic       v;
        logic       w;
        logic [3:0] a;
        logic [3:0] d;
        logic [3:0] ed_rf, ed_wf, ed_nc;
        logic       ev_rf, ev_wf, ev_nc;
    } vec_t;

    vec_t tbl [7];

    initial begin
        // Directed table, applied right after the first sweep (all words = A).
        tbl[0] = '{1'b0, 1'b1, 1'b1, 4'd3, 4'h5, 4'hA, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'h0, 4'h5, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 4'd7, 4'h2, 4'hA, 4'h2, 4'h5, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 4'd7, 4'h9, 4'h2, 4'h9, 4'h5, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 4'd7, 4'h0, 4'h9, 4'h9, 4'h9, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 4'h9, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 4'd0, 4'h0, 4'hA, 4'hA, 4'hA, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 4'h0;
        model_reset();

        // Reset state
        step();
        step();
        rst = 1'b0;
        count_sweep("sweep_len_after_reset", -1);

        // Directed vectors
        for (int k = 0; k < 7; k++) begin
            drive(tbl[k].c, tbl[k].v, tbl[k].w, tbl[k].a, tbl[k].d);
            step();
            chk($sformatf("tbl%0d_rf_data", k), rd[0], tbl[k].ed_rf);
            chk($sformatf("tbl%0d_wf_data", k), rd[1], tbl[k].ed_wf);
            chk($sformatf("tbl%0d_nc_data", k), rd[2], tbl[k].ed_nc);
            chk($sformatf("tbl%0d_rf_vld", k), rv[0], tbl[k].ev_rf);
            chk($sformatf("tbl%0d_wf_vld", k), rv[1], tbl[k].ev_wf);
            chk($sformatf("tbl%0d_nc_vld", k), rv[2], tbl[k].ev_nc);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        step();
        // registered-output instance: read of address 0 lands one cycle later
        chk("oreg_late_data", rd[3], 4'hA);
        chk("oreg_late_vld", rv[3], 1);

        // Read and clear in the same IDLE cycle: clear wins, no response
        drive(1'b1, 1'b1, 1'b0, 4'd2, 4'h0);
        step();
        chk("clear_blocks_read_vld", rv[0], 0);
        chk("clear_starts_busy", bz[0], 1);
        clear = 1'b0;
        count_sweep("sweep_len_with_clear_pulse", 5);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end

        // Let any sweep started by the random phase finish
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int n = 0; n < 40 && sweep_left > 0; n++) step();
        chk("idle_before_rst_test", bz[0], 0);

        // Reset mid-sweep, with a non-zero word visible on read_data
        drive(1'b0, 1'b1, 1'b1, 4'd1, 4'h3);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'd1, 4'h0);
        step();
        chk("pre_rst_data", rd[0], 4'h3);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        step();
        clear = 1'b0;
        for (int n = 0; n < 8; n++) step();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_data[%0d]", i), rd[i], 0);
            chk($sformatf("rst_vld[%0d]", i), rv[i], 0);
            chk($sformatf("rst_busy[%0d]", i), bz[i], 1);
            chk($sformatf("rst_ready[%0d]", i), rdy[i], 0);
        end
        step();
        step();
        rst = 1'b0;
        count_sweep("sweep_len_after_mid_rst", -1);

        // Every word reads back as INIT after the rerun sweep
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(a), 4'h0);
            step();
            chk($sformatf("init_word%0d", a), rd[0], INIT);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
